alu_ctrl: RTL and testbench

- Sequencing stage directly upstream of the 32-bit combinational ALU.
- Accepts one operation per command handshake and registers the operands and opcode.
- Drives the ALU's ina/inb/aluc/cin inputs for exactly one execute cycle, then captures the ALU output and flags.
- Presents the result on a valid/ready result port and keeps an architectural carry flag used by add-with-carry.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_ctrl_fsm.sv | 39 +++
 rtl/alu_ctrl.sv | 110 +++++++++++
 tb/tb_alu_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, state encoding and decode helpers
// for the ALU sequencing stage.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 4;

  localparam logic [3:0] OP_PASSA = 4'b0000;
  localparam logic [3:0] OP_PASSB = 4'b0001;
  localparam logic [3:0] OP_NOTA  = 4'b0010;
  localparam logic [3:0] OP_NOTB  = 4'b0011;
  localparam logic [3:0] OP_ADD   = 4'b0100;
  localparam logic [3:0] OP_ADC   = 4'b0101;
  localparam logic [3:0] OP_OR    = 4'b0110;
  localparam logic [3:0] OP_AND   = 4'b0111;
  localparam logic [3:0] OP_ZERO  = 4'b1000;
  localparam logic [3:0] OP_ONE   = 4'b1001;
  localparam logic [3:0] OP_ONES  = 4'b1010;
  localparam logic [3:0] OP_CLC   = 4'b1011;
  localparam logic [3:0] OP_STC   = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  function automatic logic is_legal(input logic [3:0] op);
    return op <= OP_STC;
  endfunction

  function automatic logic is_arith(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_ADC);
  endfunction

  function automatic logic is_flag_op(input logic [3:0] op);
    return is_arith(op) || (op == OP_CLC) || (op == OP_STC);
  endfunction

endpackage

// File: rtl/alu_ctrl_fsm.sv
// Handshake sequencer for alu_ctrl:
// IDLE accepts, EXEC lets the ALU settle, HOLD presents the result.
module alu_ctrl_fsm
  import alu_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic cmd_valid,
  input  logic res_ready,
  output logic cmd_ready,
  output logic res_valid,
  output logic accept,
  output logic cap_en
);

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (cmd_valid) state_d = EXEC;
      EXEC: state_d = HOLD;
      HOLD: if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  assign res_valid = (state_q == HOLD);
  assign accept    = cmd_ready && cmd_valid;
  assign cap_en    = (state_q == EXEC);

endmodule

// File: rtl/alu_ctrl.sv
// Sequencing stage in front of the 32-bit ALU; keeps the carry flag.
// Optional res_zero output when ALU_CTRL_ZERO_FLAG_EN is defined.
module alu_ctrl #(
  parameter int   DATA_W     = alu_pkg::DATA_W,
  parameter int   OP_W       = alu_pkg::OP_W,
  parameter logic CARRY_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic [DATA_W-1:0] alu_ina,
  output logic [DATA_W-1:0] alu_inb,
  output logic [OP_W-1:0]   alu_aluc,
  output logic              alu_cin,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_cout,
  input  logic              alu_overflow,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_carry,
  output logic              res_overflow,
  output logic              res_illegal,
`ifdef ALU_CTRL_ZERO_FLAG_EN
  output logic              res_zero,
`endif
  output logic              carry_flag
);

  import alu_pkg::*;

  logic              accept;
  logic              cap_en;
  logic [DATA_W-1:0] data_d;
  logic              carry_d;
  logic              ovf_d;
  logic              ill_d;

  alu_ctrl_fsm u_fsm (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .res_ready (res_ready),
    .cmd_ready (cmd_ready),
    .res_valid (res_valid),
    .accept    (accept),
    .cap_en    (cap_en)
  );

  assign alu_cin = carry_flag;

  // ALU out is undriven for CLC/STC/illegal codes, so those yield zero
  always_comb begin
    data_d  = '0;
    carry_d = carry_flag;
    ovf_d   = 1'b0;
    ill_d   = 1'b0;
    unique case (1'b1)
      !is_legal(alu_aluc): ill_d = 1'b1;
      is_flag_op(alu_aluc): begin
        carry_d = alu_cout;
        if (is_arith(alu_aluc)) begin
          data_d = alu_out;
          ovf_d  = alu_overflow;
        end
      end
      default: data_d = alu_out;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_ina  <= '0;
      alu_inb  <= '0;
      alu_aluc <= OP_ZERO;
    end else if (accept) begin
      alu_ina  <= cmd_a;
      alu_inb  <= cmd_b;
      alu_aluc <= cmd_op;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carry_flag   <= CARRY_INIT;
      res_data     <= '0;
      res_carry    <= 1'b0;
      res_overflow <= 1'b0;
      res_illegal  <= 1'b0;
    end else if (cap_en) begin
      carry_flag   <= carry_d;
      res_data     <= data_d;
      res_carry    <= carry_d;
      res_overflow <= ovf_d;
      res_illegal  <= ill_d;
    end
  end

`ifdef ALU_CTRL_ZERO_FLAG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       res_zero <= 1'b0;
    else if (cap_en) res_zero <= (data_d == '0);
  end
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// Scoreboard bench for alu_ctrl with a behavioural ALU attached.
// Define ALU_CTRL_ZERO_FLAG_EN to also cover res_zero.
module tb_alu_ctrl;

  import alu_pkg::*;

  localparam logic CINIT = 1'b0;

  typedef struct packed {
    logic [31:0] d;
    logic        c;
    logic        o;
    logic        i;
    logic        z;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [31:0] alu_ina;
  logic [31:0] alu_inb;
  logic [3:0]  alu_aluc;
  logic        alu_cin;
  logic [31:0] alu_out;
  logic        alu_cout;
  logic        alu_overflow;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_carry;
  logic        res_overflow;
  logic        res_illegal;
  logic        carry_flag;
`ifdef ALU_CTRL_ZERO_FLAG_EN
  logic        res_zero;
`endif

  int   errors = 0;
  int   checks = 0;
  logic mcarry = CINIT;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_ctrl #(.CARRY_INIT(CINIT)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .alu_ina      (alu_ina),
    .alu_inb      (alu_inb),
    .alu_aluc     (alu_aluc),
    .alu_cin      (alu_cin),
    .alu_out      (alu_out),
    .alu_cout     (alu_cout),
    .alu_overflow (alu_overflow),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_carry    (res_carry),
    .res_overflow (res_overflow),
    .res_illegal  (res_illegal),
`ifdef ALU_CTRL_ZERO_FLAG_EN
    .res_zero     (res_zero),
`endif
    .carry_flag   (carry_flag)
  );

  // Behavioural ALU; junk on out/cout/overflow where they mean nothing
  logic [32:0] asum;
  always_comb begin
    asum         = '0;
    alu_out      = 32'hDEAD_BEEF;
    alu_cout     = ~alu_cin;
    alu_overflow = 1'b1;
    case (alu_aluc)
      OP_PASSA: alu_out = alu_ina;
      OP_PASSB: alu_out = alu_inb;
      OP_NOTA:  alu_out = ~alu_ina;
      OP_NOTB:  alu_out = ~alu_inb;
      OP_ADD, OP_ADC: begin
        asum = {1'b0, alu_ina} + {1'b0, alu_inb}
             + {32'd0, (alu_aluc == OP_ADC) & alu_cin};
        alu_out      = asum[31:0];
        alu_cout     = asum[32];
        alu_overflow = (alu_ina[31] == alu_inb[31])
                     && (asum[31] != alu_ina[31]);
      end
      OP_OR:   alu_out = alu_ina | alu_inb;
      OP_AND:  alu_out = alu_ina & alu_inb;
      OP_ZERO: alu_out = 32'd0;
      OP_ONE:  alu_out = 32'd1;
      OP_ONES: alu_out = 32'hFFFF_FFFF;
      OP_CLC:  alu_cout = 1'b0;
      OP_STC:  alu_cout = 1'b1;
      default: ;
    endcase
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  function automatic exp_t model(input logic [3:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b,
                                 input logic cin,
                                 output logic cout);
    exp_t        e;
    logic [63:0] sx;
    e    = '0;
    cout = cin;
    if (op == OP_ADD || op == OP_ADC) begin
      sx = {{32{a[31]}}, a} + {{32{b[31]}}, b}
         + {63'd0, (op == OP_ADC) && cin};
      e.d  = sx[31:0];
      e.o  = (sx != {{32{sx[31]}}, sx[31:0]});
      cout = ({1'b0, a} + {1'b0, b}
             + {32'd0, (op == OP_ADC) && cin}) > 33'hFFFF_FFFF;
    end else begin
      case (op)
        OP_PASSA: e.d = a;
        OP_PASSB: e.d = b;
        OP_NOTA:  e.d = ~a;
        OP_NOTB:  e.d = ~b;
        OP_OR:    e.d = a | b;
        OP_AND:   e.d = a & b;
        OP_ONE:   e.d = 32'd1;
        OP_ONES:  e.d = 32'hFFFF_FFFF;
        OP_CLC:   cout = 1'b0;
        OP_STC:   cout = 1'b1;
        OP_ZERO:  e.d = 32'd0;
        default:  e.i = 1'b1;
      endcase
    end
    e.c = cout;
    e.z = (e.d == 32'd0);
    return e;
  endfunction

  task automatic issue(input logic [3:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    logic nc;
    int   n;
    sb.push_back(model(op, a, b, mcarry, nc));
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("rdy_timeout", 32'd0, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("ina", alu_ina, a);
    check("inb", alu_inb, b);
    check("aluc", {28'd0, alu_aluc}, {28'd0, op});
    check("cin", {31'd0, alu_cin}, {31'd0, mcarry});
    mcarry = nc;
  endtask

  task automatic collect(input int stall);
    exp_t        e;
    int          n;
    logic [31:0] snap;
    @(negedge clk);
    check("exec_valid", {31'd0, res_valid}, 32'd0);
    check("exec_ready", {31'd0, cmd_ready}, 32'd0);
    n = 0;
    while (!res_valid && n < 5) begin
      @(negedge clk);
      n++;
    end
    check("res_timeout", {31'd0, res_valid}, 32'd1);
    if (sb.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check("data", res_data, e.d);
      check("carry", {31'd0, res_carry}, {31'd0, e.c});
      check("ovf", {31'd0, res_overflow}, {31'd0, e.o});
      check("ill", {31'd0, res_illegal}, {31'd0, e.i});
      check("flag", {31'd0, carry_flag}, {31'd0, e.c});
`ifdef ALU_CTRL_ZERO_FLAG_EN
      check("zero", {31'd0, res_zero}, {31'd0, e.z});
`endif
    end
    snap = res_data;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      cmd_valid = (i == 1);
      cmd_op    = OP_ONES;
      check("st_valid", {31'd0, res_valid}, 32'd1);
      check("st_data", res_data, snap);
      check("st_ready", {31'd0, cmd_ready}, 32'd0);
    end
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    check("done_valid", {31'd0, res_valid}, 32'd0);
    check("done_ready", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic run(input logic [3:0] op,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input int stall);
    res_ready = (stall == 0);
    issue(op, a, b);
    collect(stall);
  endtask

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 4'd0;
    cmd_a     = 32'd0;
    cmd_b     = 32'd0;
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_valid", {31'd0, res_valid}, 32'd0);
    check("rst_data", res_data, 32'd0);
    check("rst_flag", {31'd0, carry_flag}, {31'd0, CINIT});
    check("rst_aluc", {28'd0, alu_aluc}, 32'd8);
    check("rst_ina", alu_ina, 32'd0);
    reset = 1'b0;

    run(OP_ADD, 32'h7FFF_FFFF, 32'd1, 0);
    run(OP_ADD, 32'hFFFF_FFFF, 32'd1, 0);
    run(OP_ADC, 32'd0, 32'd0, 0);
    run(OP_STC, 32'd0, 32'd0, 0);
    run(OP_OR, 32'hF0, 32'h0F, 0);

    run(OP_ADD, 32'h1234_5678, 32'h1111_1111, 5);
    check("pulse_aluc", {28'd0, alu_aluc}, {28'd0, OP_ADD});
    repeat (2) begin
      @(negedge clk);
      check("pulse_valid", {31'd0, res_valid}, 32'd0);
    end

    run(4'b1110, 32'hAAAA_AAAA, 32'h5555_5555, 0);
    run(OP_NOTA, 32'h0F0F_0F0F, 32'd0, 0);
    run(OP_PASSA, 32'hCAFE_0001, 32'h1, 0);
    run(OP_PASSB, 32'h1, 32'hBEEF_0002, 0);
    run(OP_NOTB, 32'h0, 32'h00FF_00FF, 0);
    run(OP_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 0);
    run(OP_ONE, 32'h5, 32'h6, 0);
    run(OP_ONES, 32'h5, 32'h6, 0);
    run(4'b1101, 32'h1, 32'h2, 0);
    run(4'b1111, 32'h1, 32'h2, 0);
    run(OP_CLC, 32'h0, 32'h0, 0);
    for (int k = 0; k < 8; k++) begin
      run((k % 2) ? OP_ADC : OP_ADD,
          $urandom, $urandom, 0);
    end

    res_ready = 1'b0;
    issue(OP_STC, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    check("hold_valid", {31'd0, res_valid}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", {31'd0, res_valid}, 32'd0);
    check("arst_flag", {31'd0, carry_flag}, {31'd0, CINIT});
    check("arst_ready", {31'd0, cmd_ready}, 32'd1);
    sb.delete();
    mcarry = CINIT;
    @(negedge clk);
    reset     = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    check("post_valid", {31'd0, res_valid}, 32'd0);
    run(OP_ZERO, 32'h5, 32'h6, 0);
    run(OP_ADD, 32'h1, 32'h2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
